// File: rtl/peripheral_uart_rx_drain_ctrl_wb.sv
// UART RX FIFO drain sequencer: pops received characters onto a valid/ready stream
// and raises the 16550-style receive-data-available and char-timeout requests.
module peripheral_uart_rx_drain_ctrl_wb #(
    parameter int unsigned FIFO_COUNTER_W = 5,
    parameter int unsigned REC_WIDTH      = 11,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      drain_en,
    input  logic [1:0]                trig_sel,
    input  logic                      rx_reset,
    input  logic [FIFO_COUNTER_W-1:0] rf_count,
    input  logic [REC_WIDTH-1:0]      rf_data_out,
    input  logic [9:0]                counter_t,
    output logic                      rf_pop,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [7:0]                m_data,
    output logic [2:0]                m_status,
    output logic                      rda_int,
    output logic                      cti_int,
    output logic [ERR_CNT_W-1:0]      err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_HOLD,
        S_GAP
    } state_e;

    state_e                state_q;
    logic                  rf_pop_q;
    logic                  m_valid_q;
    logic [7:0]            m_data_q;
    logic [2:0]            m_status_q;
    logic [7:0]            burst_cnt_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;

    int unsigned           trig_level;
    logic                  fifo_nonempty;
    logic                  burst_start;
    logic                  burst_continue;
    logic [7:0]            rec_data;
    logic [2:0]            rec_status;

    always_comb begin
        trig_level = 1;
        case (trig_sel)
            2'b00:   trig_level = 1;
            2'b01:   trig_level = 4;
            2'b10:   trig_level = 8;
            default: trig_level = 14;
        endcase
    end

    assign fifo_nonempty  = (rf_count != '0);
    assign rda_int        = (32'(rf_count) >= trig_level);
    assign cti_int        = (counter_t == '0) && fifo_nonempty;
    assign burst_start    = drain_en && fifo_nonempty && (rda_int || cti_int);
    assign burst_continue = drain_en && fifo_nonempty && (32'(burst_cnt_q) < MAX_BURST);
    assign rec_data       = rf_data_out[10:3];
    assign rec_status     = rf_data_out[2:0];

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            rf_pop_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_status_q  <= '0;
            burst_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (rx_reset) begin
            // Abort drops the held character; err_cnt survives a FIFO reset.
            state_q   <= S_IDLE;
            rf_pop_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (burst_start) begin
                        burst_cnt_q <= '0;
                        rf_pop_q    <= 1'b1;
                        state_q     <= S_POP;
                    end
                end
                S_POP: begin
                    rf_pop_q    <= 1'b0;
                    m_data_q    <= rec_data;
                    m_status_q  <= rec_status;
                    burst_cnt_q <= burst_cnt_q + 8'd1;
                    if ((rec_status != '0) && !(&err_cnt_q)) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                    end
                    m_valid_q   <= 1'b1;
                    state_q     <= S_HOLD;
                end
                S_HOLD: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    // rf_count has now settled after the previous pop.
                    if (burst_continue) begin
                        rf_pop_q <= 1'b1;
                        state_q  <= S_POP;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    rf_pop_q  <= 1'b0;
                    m_valid_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign rf_pop   = rf_pop_q && !rx_reset;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_status = m_status_q;
    assign err_cnt  = err_cnt_q;

endmodule
